// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes and head-flit field offsets.
// Reused by the router, packetizer and depacketizer.
package noc_pkg;

  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_BODY = 2'b10;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  // Head layout from the MSB down: type, DEST, SRC, SEQ, then zero padding.
  function automatic int dest_lsb(input int dw, input int tw, input int iw);
    return dw - tw - iw;
  endfunction

  function automatic int src_lsb(input int dw, input int tw, input int iw);
    return dw - tw - 2 * iw;
  endfunction

  function automatic int seq_lsb(input int dw, input int tw, input int iw);
    return dw - tw - 3 * iw;
  endfunction

endpackage

// File: rtl/noc_packetizer_if.sv
// Payload-in / flit-out handshake bundle of the packetizer.
// The slave modport is the packetizer side; master is its environment.
interface noc_packetizer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TYPE_WIDTH = 2,
  parameter int ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]              in_dest;
  logic [DATA_WIDTH-TYPE_WIDTH-1:0] in_data;
  logic                             in_valid;
  logic                             in_ready;
  logic [DATA_WIDTH-1:0]            out_data;
  logic                             out_valid;
  logic                             out_ready;

  modport master (
    output in_dest, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_dest, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/noc_packetizer.sv
// Source-side NoC network interface: wraps payload words into HEAD/BODY../TAIL
// packets of FlitPerPacket flits behind a registered valid/ready output.
module noc_packetizer
  import noc_pkg::*;
#(
  parameter int INDEX         = 0,
  parameter int DATA_WIDTH    = 32,
  parameter int TYPE_WIDTH    = 2,
  parameter int ID_WIDTH      = 8,
  parameter int FlitPerPacket = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  noc_packetizer_if.slave       io,
  output logic                  busy
);

  localparam int CNT_WIDTH = $clog2(FlitPerPacket);
  localparam int DEST_LSB  = dest_lsb(DATA_WIDTH, TYPE_WIDTH, ID_WIDTH);
  localparam int SRC_LSB   = src_lsb(DATA_WIDTH, TYPE_WIDTH, ID_WIDTH);
  localparam int SEQ_LSB   = seq_lsb(DATA_WIDTH, TYPE_WIDTH, ID_WIDTH);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PAYLOAD = 1'b1;

  if (FlitPerPacket < 2) begin : g_bad_flits
    $error("noc_packetizer: FlitPerPacket must be >= 2");
  end
  if (DATA_WIDTH < TYPE_WIDTH + 3 * ID_WIDTH) begin : g_bad_width
    $error("noc_packetizer: DATA_WIDTH too small for the head fields");
  end

  logic [0:0]            state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [ID_WIDTH-1:0]   seq;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic                  load_en;
  logic                  head_build;
  logic                  word_accept;
  logic                  is_tail;
  logic [DATA_WIDTH-1:0] head_flit;
  logic [DATA_WIDTH-1:0] payload_flit;

  assign load_en     = !out_valid_q || io.out_ready;
  assign io.in_ready = (state == PAYLOAD) && load_en;
  assign head_build  = (state == IDLE) && io.in_valid && load_en;
  assign word_accept = io.in_valid && io.in_ready;
  assign is_tail     = (cnt == CNT_WIDTH'(FlitPerPacket - 2));

  // The head does not consume the payload word; it stays on the bus for the first BODY.
  always_comb begin
    head_flit = '0;
    head_flit[DATA_WIDTH-1 -: TYPE_WIDTH] = TYPE_WIDTH'(FLIT_HEAD);
    head_flit[DEST_LSB +: ID_WIDTH]       = io.in_dest;
    head_flit[SRC_LSB +: ID_WIDTH]        = ID_WIDTH'(INDEX);
    head_flit[SEQ_LSB +: ID_WIDTH]        = seq;
  end

  assign payload_flit = {is_tail ? TYPE_WIDTH'(FLIT_TAIL) : TYPE_WIDTH'(FLIT_BODY), io.in_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      seq         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (head_build) begin
        out_data_q  <= head_flit;
        out_valid_q <= 1'b1;
        cnt         <= '0;
        state       <= PAYLOAD;
      end else if (word_accept) begin
        out_data_q  <= payload_flit;
        out_valid_q <= 1'b1;
        if (is_tail) begin
          state <= IDLE;
          seq   <= seq + ID_WIDTH'(1);
        end else begin
          cnt <= cnt + CNT_WIDTH'(1);
        end
      end else if (load_en) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign io.out_data  = out_data_q;
  assign io.out_valid = out_valid_q;
  assign busy         = (state == PAYLOAD) || out_valid_q;

endmodule

// File: tb/tb_noc_packetizer.sv
// Randomised bench for noc_packetizer: a packet-level queue model predicts every
// emitted flit; a second instance with FlitPerPacket=2 checks the HEAD/TAIL-only case.
module tb_noc_packetizer;

  localparam int DW  = 32;
  localparam int TW  = 2;
  localparam int IW  = 8;
  localparam int PW  = DW - TW;
  localparam int FPP = 6;
  localparam int IDX = 1;

  logic clk;
  logic rst;
  logic busy_a;
  logic busy_b;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  noc_packetizer_if #(.DATA_WIDTH(DW), .TYPE_WIDTH(TW), .ID_WIDTH(IW)) a_if ();
  noc_packetizer_if #(.DATA_WIDTH(DW), .TYPE_WIDTH(TW), .ID_WIDTH(IW)) b_if ();

  noc_packetizer #(.INDEX(IDX), .DATA_WIDTH(DW), .TYPE_WIDTH(TW), .ID_WIDTH(IW),
                   .FlitPerPacket(FPP)) dut_a (.clk(clk), .rst(rst), .io(a_if.slave), .busy(busy_a));

  noc_packetizer #(.INDEX(IDX), .DATA_WIDTH(DW), .TYPE_WIDTH(TW), .ID_WIDTH(IW),
                   .FlitPerPacket(2)) dut_b (.clk(clk), .rst(rst), .io(b_if.slave), .busy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic [DW-1:0] expq[$];
  logic [DW-1:0] outlog[$];
  int            outcyc[$];
  logic [IW-1:0] model_seq = '0;
  int            emitted   = 0;
  int            gap_cnt   = 0;
  int            stall_cnt = 0;
  int            rmode     = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: got timeout/empty expected event at t=%0t", name, $time);
  endtask

  function automatic logic [DW-1:0] head_of(input logic [IW-1:0] d, input logic [IW-1:0] s);
    return (32'h1 << 30) | (32'(d) << 22) | (32'(IDX) << 14) | (32'(s) << 6);
  endfunction

  // Router-side back-pressure: 0 always ready, 1 random, 2 the pattern 1,0,0,1.
  always begin
    int k = 0;
    a_if.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        1:       a_if.out_ready = ($urandom_range(0, 3) != 0);
        2:       begin a_if.out_ready = (k % 3 == 0); k++; end
        default: a_if.out_ready = 1'b1;
      endcase
    end
  end

  // Compare process for instance A, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
      emitted    = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 32'(a_if.out_valid), 32'd1);
        check("stall_data_held", a_if.out_data, prev_data);
      end
      if (a_if.out_valid && !a_if.out_ready) begin
        check("stall_in_ready", 32'(a_if.in_ready), 32'd0);
        stall_cnt++;
      end
      check("busy", 32'(busy_a), 32'(a_if.out_valid || (emitted % FPP != 0)));
      if (busy_a && !a_if.out_valid) gap_cnt++;
      if (a_if.out_valid && a_if.out_ready) begin
        if (expq.size() == 0) fail_now("unexpected_flit");
        else check("flit", a_if.out_data, expq.pop_front());
        outlog.push_back(a_if.out_data);
        outcyc.push_back(cyc);
        emitted++;
      end
      prev_stall = a_if.out_valid && !a_if.out_ready;
      prev_data  = a_if.out_data;
    end
  end

  // Instance B (two flits per packet): free-running stimulus and its own model.
  logic [PW-1:0] wq_b[$];
  logic [IW-1:0] seq_b     = '0;
  logic          want_head = 1'b1;
  int            heads_b   = 0;

  always begin
    b_if.in_valid  = 1'b0;
    b_if.out_ready = 1'b1;
    b_if.in_dest   = 8'h05;
    b_if.in_data   = '0;
    forever begin
      @(posedge clk); #1;
      b_if.in_valid = 1'b1;
      b_if.in_data  = PW'($urandom);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      wq_b.delete();
      seq_b     = '0;
      want_head = 1'b1;
    end else begin
      if (b_if.in_valid && b_if.in_ready) wq_b.push_back(b_if.in_data);
      if (b_if.out_valid && b_if.out_ready) begin
        if (want_head) begin
          check("b_head", b_if.out_data, head_of(8'h05, seq_b));
          seq_b++;
          heads_b++;
        end else if (wq_b.size() == 0) begin
          fail_now("b_tail_without_word");
        end else begin
          check("b_tail", b_if.out_data, {2'b11, wq_b.pop_front()});
        end
        want_head = !want_head;
      end
    end
  end

  task automatic push_word(input logic [IW-1:0] dest, input logic [PW-1:0] w);
    int guard = 0;
    a_if.in_dest  = dest;
    a_if.in_data  = w;
    a_if.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (a_if.in_ready) break;
      guard++;
      if (guard > 1000) begin
        fail_now("word_accept_timeout");
        break;
      end
    end
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
  endtask

  // Plans the full packet in the model, then offers n_send of its words.
  task automatic send_packet(input logic [IW-1:0] dest, input bit counting, input int gap_max,
                             input int gap_at, input int gap_len, input int n_send);
    logic [PW-1:0] w[FPP-1];
    for (int i = 0; i < FPP - 1; i++) w[i] = counting ? PW'(i + 1) : PW'($urandom);
    expq.push_back(head_of(dest, model_seq));
    model_seq++;
    for (int i = 0; i < FPP - 1; i++) expq.push_back({(i == FPP - 2) ? 2'b11 : 2'b10, w[i]});
    for (int i = 0; i < n_send; i++) begin
      int g;
      push_word(dest, w[i]);
      g = (i == gap_at) ? gap_len : ((gap_max > 0) ? $urandom_range(0, gap_max) : 0);
      repeat (g) @(posedge clk);
      if (g > 0) #1;
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    forever begin
      @(negedge clk); #1;
      if (expq.size() == 0) break;
      guard++;
      if (guard > 2000) begin
        fail_now("drain_timeout");
        break;
      end
    end
  endtask

  task automatic applyStimulus();
    int base;
    int g0;
    int s0;
    a_if.in_valid = 1'b0;
    a_if.in_dest  = '0;
    a_if.in_data  = '0;

    // Reset state.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(a_if.out_valid), 32'd0);
    check("rst_out_data", a_if.out_data, 32'd0);
    check("rst_in_ready", 32'(a_if.in_ready), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed packet with literal expectations.
    base = outlog.size();
    send_packet(8'd1, 1'b1, 0, -1, 0, FPP - 1);
    wait_drain();
    check("t1_head_literal", outlog[base], 32'h40404000);
    check("t1_body1_literal", outlog[base + 1], 32'h80000001);
    check("t1_tail_literal", outlog[base + 5], 32'hC0000005);
    check("t1_consecutive", 32'(outcyc[base + 5] - outcyc[base]), 32'd5);
    @(negedge clk); #1;
    check("t1_busy_after_tail", 32'(busy_a), 32'd0);

    // Stall pattern on the router side.
    rmode = 2;
    s0 = stall_cnt;
    send_packet(8'd1, 1'b1, 0, -1, 0, FPP - 1);
    wait_drain();
    check("t2_stalls_seen", 32'(stall_cnt > s0), 32'd1);
    rmode = 0;
    @(posedge clk); #1;

    // in_valid dropped for three cycles after the second word.
    g0 = gap_cnt;
    base = outlog.size();
    send_packet(8'h22, 1'b0, 0, 1, 3, FPP - 1);
    wait_drain();
    check("t4_gap_cycles", 32'(gap_cnt - g0), 32'd3);
    check("t4_resume_body", 32'(outlog[base + 3][31:30]), 32'd2);

    // Asynchronous reset mid-packet, after three payload words.
    send_packet(8'h07, 1'b0, 0, -1, 0, 3);
    #2;
    check("t5_pre_reset_valid", 32'(a_if.out_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("t5_async_valid", 32'(a_if.out_valid), 32'd0);
    check("t5_async_busy", 32'(busy_a), 32'd0);
    expq.delete();
    model_seq = '0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk); #1;

    // 300 back-to-back packets from seq 0.
    base = outlog.size();
    for (int p = 0; p < 300; p++) send_packet(IW'($urandom_range(0, 3)), 1'b0, 0, -1, 0, FPP - 1);
    wait_drain();
    check("t3_first_head_seq0", outlog[base] & 32'hC0003FC0, 32'h40000000);
    check("t3_seq255", 32'(outlog[base + 255 * FPP][13:6]), 32'd255);
    check("t3_seq_wrap", 32'(outlog[base + 256 * FPP][13:6]), 32'd0);
    check("t3_seq_last", 32'(outlog[base + 299 * FPP][13:6]), 32'd43);
    check("t3_no_bubbles", 32'(outcyc[base + 300 * FPP - 1] - outcyc[base]), 32'(300 * FPP - 1));

    // Random back-pressure, input gaps and destinations.
    rmode = 1;
    for (int p = 0; p < 25; p++) send_packet(IW'($urandom), 1'b0, 2, -1, 0, FPP - 1);
    wait_drain();
    rmode = 0;
  endtask

  task automatic checkOutput();
    check("model_queue_empty", 32'(expq.size()), 32'd0);
    check("b_packets_seen", 32'(heads_b > 100), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus();
    repeat (4) @(posedge clk);
    checkOutput();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
